// File: rtl/fpu_result_sink.sv
// rtl/fpu_result_sink.sv - FPU result capture sink with FIFO and sticky exception flags
module fpu_result_sink #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     S_req,
  input  logic                     Select,
  output logic                     S_ack,
  input  logic [DATA_W-1:0]        M1_data,
  input  logic [TAG_W-1:0]         M1_tag,
  input  logic [4:0]               M1_flags,
  input  logic [DATA_W-1:0]        M2_data,
  input  logic [TAG_W-1:0]         M2_tag,
  input  logic [4:0]               M2_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_src,
  output logic [$clog2(DEPTH):0]   count,
  output logic [4:0]               sticky_flags,
  input  logic                     clr_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {SK_IDLE = 1'b0, SK_ACK = 1'b1} sk_state_t;

  sk_state_t state_q, state_d;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic              mem_src  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;
  logic [DATA_W-1:0] cap_data;
  logic [TAG_W-1:0]  cap_tag;
  logic [4:0]        cap_flags;

  // Capture only from idle and only against the registered occupancy (no pop bypass)
  assign push      = (state_q == SK_IDLE) && S_req && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  assign cap_data  = Select ? M2_data  : M1_data;
  assign cap_tag   = Select ? M2_tag   : M1_tag;
  assign cap_flags = Select ? M2_flags : M1_flags;

  assign out_data  = mem_data[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign out_src   = mem_src[rd_ptr];

  // State register for the accept handshake
  always_ff @(posedge CLK) begin
    if (!RSTn) state_q <= SK_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and ack: one ack cycle after every capture, then back to idle
  always_comb begin
    state_d = state_q;
    S_ack   = 1'b0;
    case (state_q)
      SK_IDLE: if (push) state_d = SK_ACK;
      SK_ACK: begin
        S_ack   = 1'b1;
        state_d = SK_IDLE;
      end
      default: state_d = SK_IDLE;
    endcase
  end

  // FIFO storage; cleared on reset so the stale head reads as zero
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
        mem_src[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= cap_data;
      mem_tag[wr_ptr]  <= cap_tag;
      mem_src[wr_ptr]  <= Select;
    end
  end

  // Pointers wrap naturally; count holds on simultaneous push and pop
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky exception accumulation; clear wins over a same-cycle capture
  always_ff @(posedge CLK) begin
    if (!RSTn)          sticky_flags <= '0;
    else if (clr_flags) sticky_flags <= '0;
    else if (push)      sticky_flags <= sticky_flags | cap_flags;
  end

endmodule

// File: tb/tb_fpu_result_sink.sv
// tb/tb_fpu_result_sink.sv - self-checking bench for fpu_result_sink
module tb_fpu_result_sink;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RSTn, S_req, Select, S_ack;
  logic [DATA_W-1:0] M1_data, M2_data, out_data;
  logic [TAG_W-1:0]  M1_tag, M2_tag, out_tag;
  logic [4:0]        M1_flags, M2_flags, sticky_flags;
  logic              out_valid, out_ready, out_src, clr_flags;
  logic [2:0]        count;

  fpu_result_sink #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn), .S_req(S_req), .Select(Select), .S_ack(S_ack),
    .M1_data(M1_data), .M1_tag(M1_tag), .M1_flags(M1_flags),
    .M2_data(M2_data), .M2_tag(M2_tag), .M2_flags(M2_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_src(out_src), .count(count),
    .sticky_flags(sticky_flags), .clr_flags(clr_flags)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              src;
  } ent_t;

  ent_t        q[$];
  logic        m_ack;
  logic [4:0]  m_sticky;
  logic [TAG_W-1:0] popped[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock: advance the model from the current inputs, then compare at the falling edge
  task automatic step();
    bit   push, pop;
    ent_t e;
    logic [4:0] fl;
    if (RSTn && out_valid && out_ready) popped.push_back(out_tag);
    if (!RSTn) begin
      q.delete();
      m_ack    = 1'b0;
      m_sticky = '0;
    end else begin
      push = !m_ack && S_req && (q.size() < DEPTH);
      pop  = (q.size() > 0) && out_ready;
      if (Select) begin e.data = M2_data; e.tag = M2_tag; e.src = 1'b1; fl = M2_flags; end
      else        begin e.data = M1_data; e.tag = M1_tag; e.src = 1'b0; fl = M1_flags; end
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
      if (clr_flags) m_sticky = '0;
      else if (push) m_sticky = m_sticky | fl;
      m_ack = push;
    end
    @(posedge CLK);
    @(negedge CLK);
    check("s_ack", S_ack, m_ack);
    check("out_valid", out_valid, q.size() != 0);
    check("count", count, q.size());
    check("sticky", sticky_flags, m_sticky);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_tag", out_tag, q[0].tag);
      check("out_src", out_src, q[0].src);
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0; S_req = 1'b0; clr_flags = 1'b0;
    step();
    RSTn = 1'b1;
  endtask

  // Arbiter-style request: hold S_req until S_ack, optionally let the ack cycle pass
  task automatic send(input logic sel, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                      input logic [4:0] f, input bit finish_ack);
    bit got = 0;
    Select = sel;
    if (sel) begin M2_data = d; M2_tag = t; M2_flags = f; end
    else     begin M1_data = d; M1_tag = t; M1_flags = f; end
    S_req = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = S_ack;
    end
    if (!got) check("send_timeout", 0, 1);
    S_req = 1'b0;
    if (finish_ack) step();
  endtask

  initial begin
    RSTn = 1'b0; S_req = 1'b0; Select = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    M1_data = '0; M1_tag = '0; M1_flags = '0;
    M2_data = '0; M2_tag = '0; M2_flags = '0;
    m_ack = 1'b0; m_sticky = '0;

    // Reset state
    do_reset();
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    check("rst_src", out_src, 0);

    // Single M1 result
    send(1'b0, 32'h3F800000, 4'd3, 5'd0, 1'b0);
    check("single_ack", S_ack, 1);
    check("single_data", out_data, 32'h3F800000);
    check("single_tag", out_tag, 3);
    check("single_cnt", count, 1);
    step();
    check("single_ack_drop", S_ack, 0);

    // Fill and stall
    do_reset();
    for (int i = 0; i < 4; i++) send(i[0], $urandom, TAG_W'(i), 5'd0, 1'b1);
    check("full_cnt", count, 4);
    Select = 1'b1; M2_tag = 4'd9; S_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("stall_ack", S_ack, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("pop_cnt", count, 3);
    check("pop_noack", S_ack, 0);
    step();
    check("stall_ack_late", S_ack, 1);
    check("stall_cnt", count, 4);
    S_req = 1'b0; step();

    // Order and wrap: consumer starts after the second push
    do_reset();
    out_ready = 1'b0;
    popped.delete();
    for (int i = 0; i < 6; i++) begin
      send($urandom_range(0, 1), $urandom, TAG_W'(i), 5'd0, 1'b1);
      if (i == 1) out_ready = 1'b1;
    end
    for (int i = 0; i < 8; i++) step();
    check("wrap_n", popped.size(), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++) check("wrap_order", popped[i], i);

    // Simultaneous push and pop at count=2
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 32'h1, 4'd1, 5'd0, 1'b1);
    send(1'b1, 32'h2, 4'd2, 5'd0, 1'b1);
    Select = 1'b0; M1_tag = 4'd7; S_req = 1'b1; out_ready = 1'b1;
    step();
    S_req = 1'b0; out_ready = 1'b0;
    check("pp_cnt", count, 2);
    check("pp_head", out_tag, 2);
    step();

    // Sticky flags and clear priority
    do_reset();
    out_ready = 1'b1;
    send(1'b1, $urandom, 4'd1, 5'b00100, 1'b1);
    send(1'b0, $urandom, 4'd2, 5'b00001, 1'b1);
    check("sticky_or", sticky_flags, 5'b00101);
    Select = 1'b0; M1_flags = 5'b10000; S_req = 1'b1; clr_flags = 1'b1;
    step();
    S_req = 1'b0; clr_flags = 1'b0;
    check("sticky_clr_ack", S_ack, 1);
    check("sticky_clr", sticky_flags, 0);
    step();

    // Reset during the ack cycle with three entries held
    do_reset();
    out_ready = 1'b0;
    send(1'b0, $urandom, 4'd1, 5'b00010, 1'b1);
    send(1'b1, $urandom, 4'd2, 5'b01000, 1'b1);
    send(1'b0, $urandom, 4'd3, 5'b00001, 1'b0);
    check("pre_rst_cnt", count, 3);
    RSTn = 1'b0; step(); RSTn = 1'b1;
    check("mid_rst_ack", S_ack, 0);
    check("mid_rst_cnt", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sticky", sticky_flags, 0);
    check("mid_rst_data", out_data, 0);

    // Randomized traffic: arbiter holds, abandons, changes Select; random drain and clears
    for (int c = 0; c < 2000; c++) begin
      M1_data = $urandom; M1_tag = TAG_W'($urandom_range(0, 15)); M1_flags = 5'($urandom_range(0, 31));
      M2_data = $urandom; M2_tag = TAG_W'($urandom_range(0, 15)); M2_flags = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) Select = ~Select;
      if (S_req && S_ack)                        S_req = 1'b0;
      else if (!S_req)                           S_req = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 15) == 0)       S_req = 1'b0;
      out_ready = ($urandom_range(0, 2) == 0);
      clr_flags = ($urandom_range(0, 19) == 0);
      RSTn      = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_result_sink.md
# fpu_result_sink

Shared result sink that sits directly downstream of the FPU request arbiter. It captures one result per granted request from either the adder (M1) or the multiplier (M2), as selected by the arbiter's `Select`. It answers with a single-cycle `S_ack` and buffers results in a small FIFO that the register-file writeback port drains. It also accumulates sticky IEEE exception flags across all accepted results.

## Interface
Parameters:
- DATA_W, 32, result word width
- TAG_W, 4, destination-register tag width
- DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset, synchronous, active-low
- S_req  in  1  request from arbiter; held until S_ack is seen
- Select  in  1  0 = capture M1 (adder) bus, 1 = capture M2 (multiplier) bus; valid while S_req=1
- S_ack  out  1  registered one-cycle acknowledge to arbiter
- M1_data  in  DATA_W  adder result
- M1_tag  in  TAG_W  adder destination tag
- M1_flags  in  5  adder exception flags {NV,DZ,OF,UF,NX}
- M2_data  in  DATA_W  multiplier result
- M2_tag  in  TAG_W  multiplier destination tag
- M2_flags  in  5  multiplier exception flags
- out_valid  out  1  FIFO head valid
- out_ready  in  1  writeback consumer ready
- out_data  out  DATA_W  head result
- out_tag  out  TAG_W  head tag
- out_src  out  1  head source (0 = M1, 1 = M2)
- count  out  log2(DEPTH)+1  current occupancy
- sticky_flags  out  5  OR of flags of all accepted results since reset or clear
- clr_flags  in  1  synchronous clear of sticky_flags

## Operation
- Two-state FSM:
  - SK_IDLE: if S_req=1 and count<DEPTH (registered count), capture {data, tag, flags, Select} from the bus chosen by Select into FIFO at wr_ptr. Go to SK_ACK. Otherwise stay in SK_IDLE.
  - SK_ACK: S_ack=1 for exactly this cycle. S_req is ignored, with no capture. Return unconditionally to SK_IDLE.
- Capture condition (push): state==SK_IDLE && S_req && count<DEPTH. At most one push per two cycles.
- Pop: out_valid && out_ready. rd_ptr advances and the entry is discarded.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full (count==DEPTH): S_req is stalled in SK_IDLE with S_ack=0. Capture happens in the first cycle where the registered count<DEPTH, i.e. the cycle after a pop. There is no same-cycle pop-to-push bypass.
- Empty: out_valid=0, out_data/out_tag/out_src show the stale head entry, and the consumer ignores them.
- sticky_flags |= captured flags on each push.
  - clr_flags has priority over set in the same cycle: result = 0.
  - Flags from a push in that same cycle are dropped.
- Select changing while S_req=1 in SK_IDLE: the value sampled on the capture cycle wins.
- S_req deasserted before capture (arbiter abandoned the request): nothing is captured and no S_ack is issued.

## Timing
- Reset (RSTn=0 at a clock edge):
  - state=SK_IDLE, S_ack=0, wr_ptr=rd_ptr=0, count=0, out_valid=0, sticky_flags=0.
  - FIFO array cleared to 0, so out_data=0, out_tag=0, out_src=0.
  - Reset mid-SK_ACK drops the pending ack, and the captured entry is lost.
- Accept latency: push at edge t, S_ack=1 during cycle t+1, S_ack=0 at t+2.
- FIFO visibility: an entry pushed at edge t raises out_valid in cycle t+1 if the FIFO was empty.
- The arbiter drops S_req combinationally on S_ack and returns to idle, so no double capture occurs.
- Throughput: one result per 2 cycles maximum. The drain side can pop every cycle.

## Test plan
- Single M1 result: in SK_IDLE, S_req=1, Select=0, M1_data=0x3F800000, tag=3 -> S_ack pulses 1 cycle later, out_valid=1, out_data=0x3F800000, out_tag=3, out_src=0, count=1.
- Fill and stall, out_ready=0: 4 pushes alternating Select 0/1 -> count=4. Fifth S_req gets no S_ack. One pop -> S_ack arrives 2 cycles after the pop edge, count returns to 4.
- Order/wrap: push 6 tagged results (tags 0..5) while popping, out_ready=1 after the 2nd push -> tags drain in order 0..5 and pointers wrap cleanly.
- Simultaneous push and pop at count=2 -> count stays 2, head advances.
- Sticky flags: push with M2_flags=5'b00100, then with M1_flags=5'b00001 -> sticky_flags=5'b00101. clr_flags coincident with a push of 5'b10000 -> sticky_flags=0.
- Reset mid-operation: RSTn=0 during SK_ACK with count=3 -> next cycle S_ack=0, count=0, out_valid=0, sticky_flags=0.
